// File: rtl/gp_dcmp_pwm.sv
// 8-bit digital comparator: registered GREATER/EQUAL against a reference register,
// optionally driving complementary PWM outputs separated by a programmable dead time.
module gp_dcmp_pwm #(
    parameter string MODE             = "COMPARE",
    parameter int    GREATER_OR_EQUAL = 0,
    parameter int    DEADBAND         = 0
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       PWRDN,
    input  logic       WRAP,
    input  logic [7:0] INP,
    input  logic [7:0] INN,
    output logic       GREATER,
    output logic       EQUAL,
    output logic       OUTP,
    output logic       OUTN
);
    localparam bit         IS_PWM  = (MODE == "PWM");
    localparam bit         NO_DEAD = (DEADBAND == 0);
    localparam logic [2:0] DB_LAST = (DEADBAND > 0) ? 3'(DEADBAND - 1) : 3'd0;

    if (MODE != "COMPARE" && MODE != "PWM") begin : g_bad_mode
        $fatal(1, "gp_dcmp_pwm: MODE must be COMPARE or PWM");
    end
    if (DEADBAND < 0 || DEADBAND > 7) begin : g_bad_deadband
        $fatal(1, "gp_dcmp_pwm: DEADBAND must be in 0..7");
    end

    typedef enum logic [1:0] {IDLE, DEAD, P_ON, N_ON} stateType;

    stateType   state, stateNext;
    logic [2:0] cnt, cntNext;
    logic       target, targetNext;
    logic [7:0] refReg;
    logic       gtNow, eqNow;

    assign gtNow = (GREATER_OR_EQUAL != 0) ? (INP >= refReg) : (INP > refReg);
    assign eqNow = (INP == refReg);

    // In PWM mode the reference is a shadow that only moves at the period boundary.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            refReg  <= 8'h00;
            GREATER <= 1'b0;
            EQUAL   <= 1'b0;
        end else if (PWRDN) begin
            GREATER <= 1'b0;
            EQUAL   <= 1'b0;
        end else begin
            GREATER <= gtNow;
            EQUAL   <= eqNow;
            if (!IS_PWM || WRAP) begin
                refReg <= INN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            target <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            target <= targetNext;
        end
    end

    // The FSM samples the registered GREATER, so the drives trail it by DEADBAND+1 edges.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        targetNext = target;
        if (!IS_PWM || PWRDN) begin
            stateNext = IDLE;
            cntNext   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (NO_DEAD) begin
                        stateNext = GREATER ? P_ON : N_ON;
                    end else begin
                        stateNext  = DEAD;
                        targetNext = GREATER;
                        cntNext    = 3'd0;
                    end
                end
                DEAD: begin
                    if (GREATER != target) begin
                        targetNext = GREATER;
                        cntNext    = 3'd0;
                    end else if (cnt == DB_LAST) begin
                        stateNext = target ? P_ON : N_ON;
                    end else begin
                        cntNext = cnt + 3'd1;
                    end
                end
                P_ON: begin
                    if (!GREATER) begin
                        if (NO_DEAD) begin
                            stateNext = N_ON;
                        end else begin
                            stateNext  = DEAD;
                            targetNext = 1'b0;
                            cntNext    = 3'd0;
                        end
                    end
                end
                N_ON: begin
                    if (GREATER) begin
                        if (NO_DEAD) begin
                            stateNext = P_ON;
                        end else begin
                            stateNext  = DEAD;
                            targetNext = 1'b1;
                            cntNext    = 3'd0;
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        OUTP = IS_PWM ? (state == P_ON) : GREATER;
        OUTN = IS_PWM && (state == N_ON);
    end
endmodule

// File: tb/tb_gp_dcmp_pwm.sv
// Scoreboard bench for gp_dcmp_pwm: five configurations share one stimulus stream and are
// checked against a window-based reference model of compare result and dead-time behaviour.
module tb_gp_dcmp_pwm;
    localparam int NINST = 5;

    logic       CLK   = 1'b0;
    logic       nRST  = 1'b0;
    logic       PWRDN = 1'b0;
    logic       WRAP  = 1'b0;
    logic [7:0] INP   = 8'h00;
    logic [7:0] INN   = 8'h00;
    logic       gO[NINST];
    logic       eO[NINST];
    logic       pO[NINST];
    logic       nO[NINST];

    typedef struct {
        int               edgeNum;
        logic [NINST-1:0] g;
        logic [NINST-1:0] e;
        logic [NINST-1:0] p;
        logic [NINST-1:0] n;
    } expT;

    expT        sbQ[$];
    int         total     = 0;
    int         bad       = 0;
    int         edgeCount = 0;
    logic       prevRstn  = 1'b0;
    bit         pwmOf[NINST] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit         geOf[NINST]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int         dbOf[NINST]  = '{0, 0, 3, 0, 2};
    logic [7:0] refM[NINST];
    logic [7:0] gHist[NINST];
    int         validCnt[NINST];

    gp_dcmp_pwm #(.MODE("COMPARE"), .GREATER_OR_EQUAL(0), .DEADBAND(0)) u0 (
        .CLK(CLK), .nRST(nRST), .PWRDN(PWRDN), .WRAP(WRAP), .INP(INP), .INN(INN),
        .GREATER(gO[0]), .EQUAL(eO[0]), .OUTP(pO[0]), .OUTN(nO[0]));
    gp_dcmp_pwm #(.MODE("COMPARE"), .GREATER_OR_EQUAL(1), .DEADBAND(0)) u1 (
        .CLK(CLK), .nRST(nRST), .PWRDN(PWRDN), .WRAP(WRAP), .INP(INP), .INN(INN),
        .GREATER(gO[1]), .EQUAL(eO[1]), .OUTP(pO[1]), .OUTN(nO[1]));
    gp_dcmp_pwm #(.MODE("PWM"), .GREATER_OR_EQUAL(0), .DEADBAND(3)) u2 (
        .CLK(CLK), .nRST(nRST), .PWRDN(PWRDN), .WRAP(WRAP), .INP(INP), .INN(INN),
        .GREATER(gO[2]), .EQUAL(eO[2]), .OUTP(pO[2]), .OUTN(nO[2]));
    gp_dcmp_pwm #(.MODE("PWM"), .GREATER_OR_EQUAL(1), .DEADBAND(0)) u3 (
        .CLK(CLK), .nRST(nRST), .PWRDN(PWRDN), .WRAP(WRAP), .INP(INP), .INN(INN),
        .GREATER(gO[3]), .EQUAL(eO[3]), .OUTP(pO[3]), .OUTN(nO[3]));
    gp_dcmp_pwm #(.MODE("PWM"), .GREATER_OR_EQUAL(0), .DEADBAND(2)) u4 (
        .CLK(CLK), .nRST(nRST), .PWRDN(PWRDN), .WRAP(WRAP), .INP(INP), .INN(INN),
        .GREATER(gO[4]), .EQUAL(eO[4]), .OUTP(pO[4]), .OUTN(nO[4]));

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at edge %0d", name, act, exp, edgeCount);
        end
    endtask

    // A drive is on only when the last DEADBAND+1 compare results since the last reset or
    // power-down all agree; the forced-low result at that barrier counts as one sample.
    task automatic modelEdge(input logic [7:0] inp, input logic [7:0] inn, input logic wrap,
                             input logic pwrdn, input logic rstn, output expT x);
        x.edgeNum = edgeCount + 1;
        x.g = '0;
        x.e = '0;
        x.p = '0;
        x.n = '0;
        for (int i = 0; i < NINST; i++) begin
            logic       gv;
            logic [7:0] mask;
            mask = 8'((1 << (dbOf[i] + 1)) - 1);
            if (!rstn) begin
                refM[i]     = 8'h00;
                gHist[i]    = 8'h00;
                validCnt[i] = 1;
            end else if (pwrdn) begin
                gHist[i]    = 8'h00;
                validCnt[i] = 1;
            end else begin
                gv     = geOf[i] ? (inp >= refM[i]) : (inp > refM[i]);
                x.g[i] = gv;
                x.e[i] = (inp == refM[i]);
                if (pwmOf[i]) begin
                    if (validCnt[i] >= dbOf[i] + 1) begin
                        x.p[i] = ((gHist[i] & mask) == mask);
                        x.n[i] = ((gHist[i] & mask) == 8'h00);
                    end
                end else begin
                    x.p[i] = gv;
                end
                if (!pwmOf[i] || wrap) refM[i] = inn;
                gHist[i] = {gHist[i][6:0], gv};
                if (validCnt[i] < 8) validCnt[i]++;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] inp, input logic [7:0] inn, input logic wrap,
                                 input logic pwrdn, input logic rstn);
        expT x;
        @(negedge CLK);
        #1;
        INP   = inp;
        INN   = inn;
        WRAP  = wrap;
        PWRDN = pwrdn;
        nRST  = rstn;
        if (prevRstn && !rstn) begin
            #1;
            for (int i = 0; i < NINST; i++) begin
                checkOutput($sformatf("u%0d async reset GREATER", i), gO[i], 1'b0);
                checkOutput($sformatf("u%0d async reset EQUAL", i), eO[i], 1'b0);
                checkOutput($sformatf("u%0d async reset OUTP", i), pO[i], 1'b0);
                checkOutput($sformatf("u%0d async reset OUTN", i), nO[i], 1'b0);
            end
        end
        prevRstn = rstn;
        modelEdge(inp, inn, wrap, pwrdn, rstn, x);
        sbQ.push_back(x);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            while (sbQ.size() > 0 && sbQ[0].edgeNum <= edgeCount) begin
                expT x;
                x = sbQ.pop_front();
                for (int i = 0; i < NINST; i++) begin
                    checkOutput($sformatf("u%0d GREATER", i), gO[i], x.g[i]);
                    checkOutput($sformatf("u%0d EQUAL", i), eO[i], x.e[i]);
                    checkOutput($sformatf("u%0d OUTP", i), pO[i], x.p[i]);
                    checkOutput($sformatf("u%0d OUTN", i), nO[i], x.n[i]);
                end
            end
        end
    end

    initial begin
        logic [7:0] innCur;
        logic [7:0] inpCur;
        int         holdLeft;
        int         pdLeft;
        int         rstLeft;
        innCur   = 8'h40;
        inpCur   = 8'h00;
        holdLeft = 0;
        pdLeft   = 0;
        rstLeft  = 0;

        repeat (3) applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Equality and unsigned boundary points.
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h81, 8'h80, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);

        // Upstream 256-step counter with mid-period duty change and a one-cycle glitch.
        for (int period = 0; period < 3; period++) begin
            for (int c = 0; c < 256; c++) begin
                logic [7:0] inp;
                inp = 8'(c);
                if (period == 1 && c == 100) innCur = 8'hC0;
                if (period == 2 && c == 50) innCur = 8'($urandom_range(255));
                if (period == 1 && c == 180) inp = 8'h00;
                applyStimulus(inp, innCur, (c == 255), 1'b0, 1'b1);
            end
        end

        // Reset during a pulse, then power-down inside the following dead time.
        repeat (6) applyStimulus(8'hFF, 8'h10, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h10, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h10, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h10, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h10, 1'b0, 1'b1, 1'b1);
        repeat (8) applyStimulus(8'hFF, 8'h10, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 1500; k++) begin
            if (holdLeft == 0) begin
                case ($urandom_range(5))
                    0: inpCur = refM[$urandom_range(NINST - 1)];
                    1: inpCur = refM[$urandom_range(NINST - 1)] + 8'd1;
                    2: inpCur = refM[$urandom_range(NINST - 1)] - 8'd1;
                    3: inpCur = 8'h00;
                    4: inpCur = 8'hFF;
                    default: inpCur = 8'($urandom_range(255));
                endcase
                holdLeft = $urandom_range(6, 1);
            end
            holdLeft--;
            if (pdLeft == 0 && $urandom_range(19) == 0) pdLeft = $urandom_range(4, 1);
            if (rstLeft == 0 && $urandom_range(149) == 0) rstLeft = $urandom_range(3, 1);
            if ($urandom_range(3) == 0) innCur = 8'($urandom_range(255));
            applyStimulus(inpCur, innCur, ($urandom_range(5) == 0), (pdLeft > 0), (rstLeft == 0));
            if (pdLeft > 0) pdLeft--;
            if (rstLeft > 0) rstLeft--;
        end

        repeat (2) @(negedge CLK);
        #1;
        total++;
        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
